// File: rtl/muldiv_defs.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and counter sizing.
package muldiv_defs;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(MD_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring
// shift-subtract divide over the {acc, quo} register pair.
module muldiv_step
  import muldiv_defs::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] operand,
  input  logic             div_mode,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    sum     = {1'b0, acc} + (quo[0] ? {1'b0, operand} : '0);
    shifted = {acc, quo[WIDTH-1]};
    fits    = (shifted >= {1'b0, operand});
    // Remainder is always below the divisor, so the low WIDTH bits suffice.
    diff    = shifted[WIDTH-1:0] - operand;
    if (div_mode) begin
      acc_next = fits ? diff : shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], fits};
    end else begin
      acc_next = sum[WIDTH:1];
      quo_next = {sum[0], quo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers;
// one iteration per cycle, WIDTH iterations per operation.
module muldiv
  import muldiv_defs::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       muldivop,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hiwrite,
  input  logic             lowrite,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, quo, opb;
  logic             op_div, neg_main, neg_rem;
  logic             accept, last;

  md_op_e           op;
  logic             is_div, is_signed, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [WIDTH-1:0]   acc_step, quo_step;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, hi_res, lo_res;

  // Operand conditioning at launch: magnitudes for signed ops, raw otherwise.
  assign op        = md_op_e'(muldivop);
  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign sign_a    = is_signed & srca[WIDTH-1];
  assign sign_b    = is_signed & srcb[WIDTH-1];
  assign mag_a     = sign_a ? (WIDTH'(0) - srca) : srca;
  assign mag_b     = sign_b ? (WIDTH'(0) - srcb) : srcb;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .quo      (quo),
    .operand  (opb),
    .div_mode (op_div),
    .acc_next (acc_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_CALC;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (count == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Final sign fix-up applied to the last iteration's output.
  always_comb begin
    prod     = {acc_step, quo_step};
    prod_fix = neg_main ? ((2*WIDTH)'(0) - prod) : prod;
    q_fix    = neg_main ? (WIDTH'(0) - quo_step) : quo_step;
    r_fix    = neg_rem  ? (WIDTH'(0) - acc_step) : acc_step;
    hi_res   = op_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = op_div ? q_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      acc      <= '0;
      quo      <= '0;
      opb      <= '0;
      op_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      busy <= (state_next == S_CALC);
      done <= (state_next == S_DONE);
      if (accept) begin
        acc      <= '0;
        quo      <= mag_a;
        opb      <= mag_b;
        op_div   <= is_div;
        // Divide by zero keeps the all-ones quotient unsigned.
        neg_main <= (sign_a ^ sign_b) & ~(is_div & (srcb == '0));
        neg_rem  <= sign_a & is_div;
        count    <= '0;
      end else if (state == S_CALC) begin
        acc   <= acc_step;
        quo   <= quo_step;
        count <= count + CW'(1);
      end
      if (state != S_CALC) begin
        if (hiwrite) hi <= srca;
        if (lowrite) lo <= srca;
      end else if (last) begin
        hi <= hi_res;
        lo <= lo_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: vector table for arithmetic results plus
// hand-written sequences for interference, back-to-back and reset abort.
module tb_muldiv;

  localparam int unsigned W = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic         clk = 1'b0;
  logic         reset, start, hiwrite, lowrite;
  logic [1:0]   muldivop;
  logic [W-1:0] srca, srcb;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[11];

  muldiv #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .muldivop (muldivop),
    .srca     (srca),
    .srcb     (srcb),
    .hiwrite  (hiwrite),
    .lowrite  (lowrite),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) check("busy_done_exclusive", W'(busy & done), '0);
  end

  // Launch one op from the current negedge; lat counts samples after the
  // start edge until done (33 = done in the cycle after edge E32).
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int start_at, input int hiw_at,
                        output int lat, output int busy_cyc, output logic [W-1:0] hi_mid);
    start    = 1'b1;
    muldivop = op;
    srca     = a;
    srcb     = b;
    @(negedge clk);
    muldivop = op ^ 2'b11;
    srca     = '0;
    srcb     = '0;
    lat      = -1;
    busy_cyc = 0;
    hi_mid   = hi;
    for (int n = 1; n <= 40; n++) begin
      start   = 1'b0;
      hiwrite = 1'b0;
      if (n == hiw_at + 1) hi_mid = hi;
      if (busy) busy_cyc++;
      if (done) begin
        lat = n;
        break;
      end
      if (n == start_at) begin
        start    = 1'b1;
        muldivop = OP_DIVU;
        srca     = 32'd99;
        srcb     = 32'd3;
      end
      if (n == hiw_at) begin
        hiwrite = 1'b1;
        srca    = 32'h0000_1234;
      end
      @(negedge clk);
    end
    start   = 1'b0;
    hiwrite = 1'b0;
  endtask

  initial begin
    int           lat, bc, seen;
    logic [W-1:0] hm, prev_hi;

    reset = 1'b1; start = 1'b0; hiwrite = 1'b0; lowrite = 1'b0;
    muldivop = '0; srca = '0; srcb = '0;

    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[6]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8]  = '{OP_MULT,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[9]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
    vecs[10] = '{OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, lat, bc, hm);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("v%0d_latency", i), W'(lat), 32'd33);
      check($sformatf("v%0d_busy_cycles", i), W'(bc), 32'd32);
      @(negedge clk);
    end

    // start at cycle 5 and MTHI at cycle 7 while busy must both be ignored
    prev_hi = hi;
    run_op(OP_MULTU, 32'd6, 32'd7, 5, 7, lat, bc, hm);
    check("intf_hi_mid", hm, prev_hi);
    check("intf_hi", hi, 32'd0);
    check("intf_lo", lo, 32'd42);
    check("intf_latency", W'(lat), 32'd33);

    // back-to-back: second start issued in the done cycle
    run_op(OP_MULTU, 32'd3, 32'd5, 0, 0, lat, bc, hm);
    check("b2b1_lo", lo, 32'd15);
    check("b2b1_hi", hi, 32'd0);
    run_op(OP_DIVU, 32'd50, 32'd6, 0, 0, lat, bc, hm);
    check("b2b2_latency", W'(lat), 32'd33);
    check("b2b2_lo", lo, 32'd8);
    check("b2b2_hi", hi, 32'd2);
    @(negedge clk);
    check("idle_busy", W'(busy), '0);
    check("idle_done", W'(done), '0);

    // MTLO in idle
    lowrite = 1'b1; srca = 32'h0000_ABCD;
    @(negedge clk);
    lowrite = 1'b0; srca = '0;
    check("mtlo_lo", lo, 32'h0000_ABCD);
    check("mtlo_hi", hi, 32'd2);

    // MTHI together with start: applied at the start edge, then overwritten
    hiwrite = 1'b1;
    run_op(OP_MULTU, 32'h55, 32'd2, 0, 0, lat, bc, hm);
    check("mthi_start_mid", hm, 32'h55);
    check("mthi_start_hi", hi, 32'd0);
    check("mthi_start_lo", lo, 32'hAA);
    @(negedge clk);

    // reset at cycle 10 of a DIVU aborts with no done
    start = 1'b1; muldivop = OP_DIVU; srca = 32'd100; srcb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", W'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", W'(seen), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit for the MIPS execute stage. It takes the same `srca`/`srcb` operands as the ALU and executes MULT, MULTU, DIV and DIVU over 32 cycles. Results go into architectural HI/LO registers, which feed the writeback result mux alongside `aluout` for MFHI/MFLO. The controller stalls the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch operation; sampled on the clock edge.
- `muldivop`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srca`  in  WIDTH  multiplicand/dividend; also MTHI/MTLO write data.
- `srcb`  in  WIDTH  multiplier/divisor.
- `hiwrite`  in  1  MTHI: HI <= `srca`.
- `lowrite`  in  1  MTLO: LO <= `srca`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse, high in the first cycle new HI/LO are visible.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, DONE.
- IDLE/DONE with `start`=1: latch |operands| (signed ops) or raw operands (unsigned ops), latch the sign flags, clear the accumulator, set count=0, go to CALC.
- IDLE/DONE with `start`=0: go to IDLE (DONE lasts exactly one cycle).
- CALC: one iteration per cycle; after count=WIDTH-1, apply sign fix-up, write HI/LO, go to DONE.
- Multiply: radix-2 shift-add, 2·WIDTH-bit product. HI = upper half, LO = lower half. MULT negates the product when the operand signs differ.
- Divide: restoring shift-subtract. LO = quotient, HI = remainder. DIV negates the quotient when the signs differ; the remainder takes the dividend's sign.
- Divide by zero (either DIV or DIVU): LO = 0xFFFFFFFF, HI = `srca`, no sign fix-up. The unit never traps.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (two's-complement wrap).
- `start` while `busy`: ignored; the operands in flight are unaffected.
- `hiwrite`/`lowrite` while `busy`: ignored.
- `hiwrite`/`lowrite` in IDLE/DONE: applied at the edge, including when `start` is asserted in the same cycle. The later result overwrites them.
- `muldivop` is sampled only on the `start` edge.

## Timing
- Reset: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, count=0. Reset mid-operation aborts the operation, and no `done` follows.
- Let edge E0 be the edge where `start` is sampled in IDLE/DONE.
- `busy`=1 in the cycles after E0 through E32 (32 cycles).
- HI/LO update at edge E32. `done`=1 and `busy`=0 in the cycle after E32.
- Latency: 32 cycles from the start edge to visible results.
- `start` in the `done` cycle is accepted; back-to-back throughput is one operation per 33 cycles.
- `busy` and `done` are never high together.
- `hi`/`lo` are registered outputs and hold their values between updates.

## Structure
- Shared package/header `muldiv_defs` holds:
  - `muldivop` encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), which the main decoder shares;
  - state encodings;
  - the count width, $clog2(WIDTH).
- One sub-module, `muldiv_step`: combinational single iteration. Inputs: accumulator, operand, mode. Outputs: next accumulator and next quotient/product bits. The top level holds the FSM, counter, sign logic and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` exactly 33 cycles after the start edge; `busy` high for 32 cycles.
- MULT −3 × 7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIV −7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100 / 7 -> `lo`=14, `hi`=2.
- DIVU 5 / 0 -> `lo`=0xFFFFFFFF, `hi`=5. DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Interference while `busy`:
  - `start` with new operands at cycle 5 -> ignored; the original result returned.
  - `hiwrite` with `srca`=0x1234 at cycle 7 -> HI unaffected.
- Back-to-back: new `start` in the `done` cycle -> accepted; second `done` 33 cycles later. MTLO 0xABCD in IDLE -> `lo`=0xABCD next cycle.
- `reset` asserted at cycle 10 of a DIVU -> next cycle `busy`=0, `done`=0, `hi`=`lo`=0; no `done` within 40 subsequent cycles.
